// File: rtl/hour_chime_gen_if.sv
// hour_chime_gen_if
//   Bundles the BCD time bus, chime controls and chime status between the
//   time counters (master side) and the hourly chime generator (slave side).
//   Signals:
//     hour, minute, second : BCD time of day
//     en                   : chime enable
//     day_set              : 1 = 24 h pulse count, 0 = 12 h pulse count
//     hour_alarm           : chime pulse train
//     busy                 : train in progress
//     last                 : pulses remaining, including the current one
//     hour_out_tmp         : pulse total of the current / most recent train
interface hour_chime_gen_if;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       en;
  logic       day_set;
  logic       hour_alarm;
  logic       busy;
  logic [4:0] last;
  logic [4:0] hour_out_tmp;

  modport master (
    output hour, minute, second, en, day_set,
    input  hour_alarm, busy, last, hour_out_tmp
  );

  modport slave (
    input  hour, minute, second, en, day_set,
    output hour_alarm, busy, last, hour_out_tmp
  );
endinterface

// File: rtl/hour_chime_gen.sv
// hour_chime_gen
//   Hourly chime generator. On each hour boundary (and optionally at half
//   past) it emits a train of pulses whose count equals the hour, with
//   programmable pulse/gap lengths and an optional quiet-hours window.
//   Ports:
//     clk_1hz : single clock, all state on the rising edge
//     cr      : asynchronous active-low reset
//     bus     : slave side of hour_chime_gen_if (time in, chime status out)
module hour_chime_gen #(
  parameter int unsigned ON_CYCLES   = 1,
  parameter int unsigned OFF_CYCLES  = 1,
  parameter bit          HALF_EN     = 1'b1,
  parameter bit          QUIET_EN    = 1'b0,
  parameter int unsigned QUIET_START = 22,
  parameter int unsigned QUIET_END   = 7
) (
  input  logic             clk_1hz,
  input  logic             cr,
  hour_chime_gen_if.slave  bus
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned PW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
  localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYCLES - 1);
  localparam logic [PW-1:0] OFF_LAST = PW'(OFF_CYCLES - 1);
  localparam logic [7:0]    QS       = 8'(QUIET_START);
  localparam logic [7:0]    QE       = 8'(QUIET_END);

  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [PW-1:0] phase_r, phase_s;
  logic [4:0]    last_r, last_s;
  logic [4:0]    total_r, total_s;
  logic          alarm_r, alarm_s;
  logic          busy_r, busy_s;
  logic          prev_match_r;

  logic       hour_match_s, half_match_s, match_s, trigger_s;
  logic [7:0] h_s;
  logic [4:0] h5_s, h12_s, n_s;
  logic       valid_s, quiet_s, fire_s;

  assign hour_match_s = (bus.minute == 8'h00) && (bus.second == 8'h00);
  assign half_match_s = HALF_EN && (bus.minute == 8'h30) && (bus.second == 8'h00);
  assign match_s      = hour_match_s || half_match_s;
  assign trigger_s    = match_s && !prev_match_r;

  // Binary hour; nibbles above 9 are rejected by valid_s, not here.
  assign h_s     = ({4'd0, bus.hour[7:4]} * 8'd10) + {4'd0, bus.hour[3:0]};
  assign valid_s = (bus.hour[7:4] <= 4'd9) && (bus.hour[3:0] <= 4'd9) && (h_s <= 8'd23);
  // Only meaningful once valid_s holds, when h fits in 5 bits.
  assign h5_s    = h_s[4:0];
  assign h12_s   = (h5_s >= 5'd12) ? (h5_s - 5'd12) : h5_s;

  // Window wraps past midnight when START > END; START == END is empty.
  assign quiet_s = QUIET_EN && (
                     (QS < QE) ? ((h_s >= QS) && (h_s < QE)) :
                     (QS > QE) ? ((h_s >= QS) || (h_s < QE)) : 1'b0);

  // Pulse count for the trigger: half-hour is always a single chime.
  always_comb begin
    n_s = 5'd1;
    if (hour_match_s) begin
      if (bus.day_set) begin
        n_s = (h5_s == 5'd0) ? 5'd24 : h5_s;
      end else begin
        n_s = (h12_s == 5'd0) ? 5'd12 : h12_s;
      end
    end else begin
      n_s = 5'd1;
    end
  end

  assign fire_s = trigger_s && bus.en && valid_s && !quiet_s;

  // Next-state and next-output logic for the IDLE/ON/OFF pulse sequencer.
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    last_s  = last_r;
    total_s = total_r;
    alarm_s = alarm_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          state_s = ON;
          phase_s = '0;
          last_s  = n_s;
          total_s = n_s;
          alarm_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ON: begin
        if (!bus.en) begin
          state_s = IDLE;
          phase_s = '0;
          last_s  = 5'd0;
          alarm_s = 1'b0;
          busy_s  = 1'b0;
        end else if (phase_r == ON_LAST) begin
          state_s = OFF;
          phase_s = '0;
          alarm_s = 1'b0;
        end else begin
          phase_s = phase_r + PW'(1);
        end
      end
      OFF: begin
        if (!bus.en) begin
          state_s = IDLE;
          phase_s = '0;
          last_s  = 5'd0;
          alarm_s = 1'b0;
          busy_s  = 1'b0;
        end else if (phase_r == OFF_LAST) begin
          phase_s = '0;
          if (last_r == 5'd1) begin
            state_s = IDLE;
            last_s  = 5'd0;
            busy_s  = 1'b0;
          end else begin
            state_s = ON;
            last_s  = last_r - 5'd1;
            alarm_s = 1'b1;
          end
        end else begin
          phase_s = phase_r + PW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        phase_s = '0;
        last_s  = 5'd0;
        alarm_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters, match history and registered outputs.
  always_ff @(posedge clk_1hz or negedge cr) begin
    if (!cr) begin
      state_r      <= IDLE;
      phase_r      <= '0;
      last_r       <= 5'd0;
      total_r      <= 5'd0;
      alarm_r      <= 1'b0;
      busy_r       <= 1'b0;
      prev_match_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      last_r       <= last_s;
      total_r      <= total_s;
      alarm_r      <= alarm_s;
      busy_r       <= busy_s;
      prev_match_r <= match_s;
    end
  end

  assign bus.hour_alarm   = alarm_r;
  assign bus.busy         = busy_r;
  assign bus.last         = last_r;
  assign bus.hour_out_tmp = total_r;

endmodule

// File: tb/tb_hour_chime_gen.sv
// tb_hour_chime_gen
//   Directed bench for hour_chime_gen. Three instances share the stimulus:
//   defaults, quiet window enabled (22..7), and 3-on/2-off pulse shaping.
module tb_hour_chime_gen;
  logic clk_1hz = 1'b0;
  logic cr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_1hz = ~clk_1hz;

  hour_chime_gen_if if_def ();
  hour_chime_gen_if if_q ();
  hour_chime_gen_if if_l ();

  hour_chime_gen u_def (.clk_1hz(clk_1hz), .cr(cr), .bus(if_def.slave));
  hour_chime_gen #(.QUIET_EN(1'b1), .QUIET_START(22), .QUIET_END(7))
    u_quiet (.clk_1hz(clk_1hz), .cr(cr), .bus(if_q.slave));
  hour_chime_gen #(.ON_CYCLES(3), .OFF_CYCLES(2))
    u_long (.clk_1hz(clk_1hz), .cr(cr), .bus(if_l.slave));

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                       input logic e, input logic ds);
    if_def.hour = h; if_def.minute = m; if_def.second = s; if_def.en = e; if_def.day_set = ds;
    if_q.hour   = h; if_q.minute   = m; if_q.second   = s; if_q.en   = e; if_q.day_set   = ds;
    if_l.hour   = h; if_l.minute   = m; if_l.second   = s; if_l.en   = e; if_l.day_set   = ds;
  endtask

  function automatic logic get_alarm(input int sel);
    case (sel)
      1:       return if_q.hour_alarm;
      2:       return if_l.hour_alarm;
      default: return if_def.hour_alarm;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1:       return if_q.busy;
      2:       return if_l.busy;
      default: return if_def.busy;
    endcase
  endfunction

  function automatic int get_last(input int sel);
    case (sel)
      1:       return int'(if_q.last);
      2:       return int'(if_l.last);
      default: return int'(if_def.last);
    endcase
  endfunction

  function automatic int get_total(input int sel);
    case (sel)
      1:       return int'(if_q.hour_out_tmp);
      2:       return int'(if_l.hour_out_tmp);
      default: return int'(if_def.hour_out_tmp);
    endcase
  endfunction

  // Idle at a non-matching time long enough for every instance to finish.
  task automatic settle(input int n);
    apply(8'h01, 8'h05, 8'h00, 1'b1, 1'b1);
    repeat (n) @(negedge clk_1hz);
  endtask

  // Samples one instance on falling edges for a fixed window.
  task automatic measure(input int sel, input int cycles, output int pulses,
                         output int busy_cyc, output int first_last, output logic [15:0] pat);
    logic a, pa;
    pa = 1'b0; pulses = 0; busy_cyc = 0; first_last = -1; pat = 16'h0000;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_1hz);
      a = get_alarm(sel);
      if (i < 16) pat[15 - i] = a;
      if (a && !pa) begin
        pulses++;
        if (pulses == 1) first_last = get_last(sel);
      end
      if (get_busy(sel)) busy_cyc++;
      pa = a;
    end
  endtask

  // Bounded wait on default instance for the n-th rising edge of hour_alarm.
  task automatic wait_pulses(input int n, output int got);
    logic a, pa;
    pa = 1'b0; got = 0;
    for (int i = 0; i < 100 && got < n; i++) begin
      @(negedge clk_1hz);
      a = if_def.hour_alarm;
      if (a && !pa) got++;
      pa = a;
    end
  endtask

  int p, b, fl, got;
  logic [15:0] pat;
  logic [9:0]  exp_pat;

  initial begin
    cr = 1'b0;
    apply(8'h01, 8'h05, 8'h00, 1'b1, 1'b1);
    repeat (3) @(negedge clk_1hz);
    check_val("rst_alarm", int'(if_def.hour_alarm), 0);
    check_val("rst_busy",  int'(if_def.busy), 0);
    check_val("rst_last",  int'(if_def.last), 0);
    check_val("rst_total", int'(if_def.hour_out_tmp), 0);
    cr = 1'b1;
    settle(3);

    // 13:00:00, 24 h count
    apply(8'h13, 8'h00, 8'h00, 1'b1, 1'b1);
    measure(0, 70, p, b, fl, pat);
    check_val("h13_24_pulses", p, 13);
    check_val("h13_24_busy", b, 26);
    check_val("h13_24_first_last", fl, 13);
    check_val("h13_24_total", get_total(0), 13);
    settle(130);

    // 13:00:00, 12 h count
    apply(8'h13, 8'h00, 8'h00, 1'b1, 1'b0);
    measure(0, 70, p, b, fl, pat);
    check_val("h13_12_pulses", p, 1);
    check_val("h13_12_total", get_total(0), 1);
    settle(130);

    // midnight, both counts
    apply(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    measure(0, 70, p, b, fl, pat);
    check_val("h00_12_pulses", p, 12);
    settle(130);
    apply(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    measure(0, 70, p, b, fl, pat);
    check_val("h00_24_pulses", p, 24);
    check_val("h00_24_busy", b, 48);
    settle(130);

    // half-hour single chime, held for 70 cycles
    apply(8'h15, 8'h30, 8'h00, 1'b1, 1'b1);
    measure(0, 70, p, b, fl, pat);
    check_val("half_pulses", p, 1);
    check_val("half_busy", b, 2);
    settle(130);

    // quiet window 22..7
    apply(8'h23, 8'h00, 8'h00, 1'b1, 1'b1);
    measure(1, 70, p, b, fl, pat);
    check_val("quiet_h23_pulses", p, 0);
    settle(130);
    apply(8'h07, 8'h00, 8'h00, 1'b1, 1'b1);
    measure(1, 70, p, b, fl, pat);
    check_val("quiet_h07_pulses", p, 7);
    settle(130);
    apply(8'h06, 8'h00, 8'h00, 1'b1, 1'b1);
    measure(1, 70, p, b, fl, pat);
    check_val("quiet_h06_pulses", p, 0);
    check_val("quiet_h06_busy", b, 0);
    settle(130);

    // invalid BCD hours
    apply(8'h24, 8'h00, 8'h00, 1'b1, 1'b1);
    measure(0, 20, p, b, fl, pat);
    check_val("bad_h24_pulses", p, 0);
    check_val("bad_h24_busy", b, 0);
    settle(130);
    apply(8'h1A, 8'h00, 8'h00, 1'b1, 1'b1);
    measure(0, 20, p, b, fl, pat);
    check_val("bad_h1A_pulses", p, 0);
    check_val("bad_h1A_busy", b, 0);
    settle(130);

    // 3-on / 2-off shaping at hour 02
    apply(8'h02, 8'h00, 8'h00, 1'b1, 1'b1);
    measure(2, 16, p, b, fl, pat);
    exp_pat = 10'b1110011100;
    check_val("long_pattern", int'(pat[15:6]), int'(exp_pat));
    check_val("long_tail", int'(pat[5:0]), 0);
    check_val("long_busy", b, 10);
    settle(130);

    // en dropped after pulse 5 at hour 21
    apply(8'h21, 8'h00, 8'h00, 1'b1, 1'b1);
    wait_pulses(5, got);
    check_val("abort_reach_p5", got, 5);
    check_val("abort_last_p5", int'(if_def.last), 17);
    @(negedge clk_1hz);
    apply(8'h21, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk_1hz);
    check_val("abort_alarm", int'(if_def.hour_alarm), 0);
    check_val("abort_busy", int'(if_def.busy), 0);
    check_val("abort_last", int'(if_def.last), 0);
    check_val("abort_total", int'(if_def.hour_out_tmp), 21);
    apply(8'h21, 8'h00, 8'h00, 1'b1, 1'b1);
    measure(0, 10, p, b, fl, pat);
    check_val("en_raise_mid_match", p, 0);
    settle(130);

    // reset asserted mid-train
    apply(8'h21, 8'h00, 8'h00, 1'b1, 1'b1);
    wait_pulses(3, got);
    check_val("reset_reach_p3", got, 3);
    cr = 1'b0;
    #1;
    check_val("midrst_alarm", int'(if_def.hour_alarm), 0);
    check_val("midrst_busy",  int'(if_def.busy), 0);
    check_val("midrst_last",  int'(if_def.last), 0);
    check_val("midrst_total", int'(if_def.hour_out_tmp), 0);
    @(negedge clk_1hz);
    apply(8'h01, 8'h05, 8'h00, 1'b1, 1'b1);
    cr = 1'b1;
    measure(0, 5, p, b, fl, pat);
    check_val("post_rst_idle", b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
